i2s_rx_capture: RTL
===================

Name: i2s_rx_capture

Overview:
- I2S receive path for the audio Pmod ADC (line-in/microphone side), the capture counterpart of the speaker DAC transmitter.
- Generates the same master clocks as the playback path: mclk = clk/4, sclk = clk/16, lrclk = clk/512.
- Deserialises the ADC serial output into 16-bit signed left/right samples.
- Presents each completed stereo frame on a valid/ready handshake to downstream logic (level meter, recorder).

Parameters:
- WIDTH, 16, sample width in bits; must equal the number of sclk periods per lrclk half (16).
- I2S_DELAY, 1, 1 = standard I2S (MSB one sclk after lrclk edge); 0 = left-justified.
- SYNC_STAGES, 2, synchroniser depth on sdout (minimum 2).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- en  in  1  capture enable
- sdout  in  1  serial data from ADC (asynchronous to clk)
- mclk  out  1  master clock to ADC, div[1]
- sclk  out  1  bit clock, div[3]
- lrclk  out  1  word select, div[8]; 0 = left, 1 = right
- left_sample  out  WIDTH  signed left sample
- right_sample  out  WIDTH  signed right sample
- sample_valid  out  1  frame available
- sample_ready  in  1  consumer accepts frame
- overrun  out  1  sticky: frame dropped/overwritten
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset: div = 0; mclk, sclk, lrclk = 0; samples = 0; sample_valid = 0; overrun = 0; shift register = 0; prime = 0.
- Clock generation:
  - 9-bit free-running counter div increments every clk while en = 1.
  - While en = 0, div is held at 0 and all clock outputs are 0.
  - All clock outputs are registered bits of div (glitch-free).
- Input path: sdout passes through SYNC_STAGES flops.
- Bit sampling:
  - sample strobe fires when div[3:0] == 4'd9, i.e. sclk rising edge at div[3:0] = 8 plus one cycle margin.
  - Synchronised bit is shifted MSB-first into a WIDTH-bit shift register.
  - Bit slot = div[7:4]; half = div[8].
- Word completion with I2S_DELAY = 1:
  - Slot 0 carries the LSB of the previous half's word.
  - Word completes at the strobe of slot 0; it belongs to channel ~div[8].
- Word completion with I2S_DELAY = 0: word completes at the strobe of slot 15 of the same half.
- Completed left word goes to a staging register.
- Completed right word triggers frame commit in the same cycle: left_sample <= staging, right_sample <= word.
- Prime:
  - After reset or an en rising edge, the first right completion only sets prime = 1 and does not commit.
  - Commits occur only with prime = 1, so the partial first frame is discarded.
  - en = 0 clears prime.
- Handshake:
  - sample_valid goes to 1 the cycle after a commit and holds until a cycle with sample_valid && sample_ready, then goes to 0 next cycle.
  - Output data is stable while valid = 1 except on overrun.
  - Commit while valid && !ready: data is overwritten, valid stays 1, overrun <= 1.
  - Commit in the same cycle as an accept: no overrun, valid stays 1 with new data.
- Overrun is cleared by ovr_clr; ovr_clr in the same cycle as a new overrun leaves overrun = 1 (set wins).
- Frame rate: one commit per 512 clk (195.3 kHz at 100 MHz).
- Latency: from the right-word final strobe, 1 cycle to sample_valid.
- en dropped mid-frame: shift register and staging are cleared, outputs hold, and valid is unaffected by en.

Optional Feature:
- Macro: I2S_RX_PEAK_EN.
- With the macro defined:
  - Adds output peak_level[WIDTH-2:0] and input peak_clr.
  - On each commit, peak <= max(peak, |left|, |right|); |-32768| saturates to 15'h7FFF.
  - peak_clr zeroes peak; a simultaneous commit loads that frame's max instead.
  - peak_level resets to 0.
- Without the macro: no such ports or logic.

Decomposition:
- Shared package i2s_pkg holds:
  - divider bit indices: MCLK_BIT = 1, SCLK_BIT = 3, LRCLK_BIT = 8;
  - SAMPLE_PHASE = 4'd9;
  - SLOTS_PER_HALF = 16.
- The playback path uses the same constants.
- One sub-module: i2s_clkgen (9-bit divider + registered mclk/sclk/lrclk outputs), which the speaker path can reuse.

Test Plan:
- ADC model drives standard I2S, left = 16'h1234, right = 16'hEDCC, ready tied 1, en = 1 from reset → first frame discarded; every subsequent 512-clk period valid pulses one cycle with left = 16'h1234, right = 16'hEDCC.
- Measure outputs, en = 1 → mclk period 4 clk, sclk period 16 clk, lrclk period 512 clk, lrclk edges coincident with sclk falling edges.
- Hold ready = 0 across two commits (left 16'h0001 then 16'h0002) → valid stays 1, data = 16'h0002, overrun = 1; ovr_clr clears overrun.
- Assert ready in exactly the commit cycle → no overrun, new frame presented, valid continuous.
- Deassert en mid right word for 100 clk, re-enable → clocks low while disabled, next frame discarded, following frame correct; assert rst mid-frame → all outputs 0 immediately.
- With I2S_RX_PEAK_EN: frames left = 16'h8000, right = 16'h0100 → peak_level = 15'h7FFF; peak_clr with next frame left = 16'h0010, right = 16'hFFF0 → peak_level = 15'h0010.

Source files
------------

// File: rtl/i2s_pkg.sv
// Divider bit map and slot timing shared by the I2S capture and playback paths.
package i2s_pkg;

  localparam int MCLK_BIT  = 1;
  localparam int SCLK_BIT  = 3;
  localparam int LRCLK_BIT = 8;
  localparam int DIV_WIDTH = LRCLK_BIT + 1;

  localparam logic [3:0] SAMPLE_PHASE   = 4'd9;
  localparam int         SLOTS_PER_HALF = 16;
  localparam logic [3:0] LAST_SLOT      = 4'(SLOTS_PER_HALF - 1);

  // Polarity matches lrclk: low half carries left, high half carries right.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running 9-bit divider producing registered mclk/sclk/lrclk; all held low while en = 0.
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [DIV_WIDTH-1:0] div,
  output logic                 mclk,
  output logic                 sclk,
  output logic                 lrclk
);

  logic [DIV_WIDTH-1:0] div_nxt;

  assign div_nxt = en ? div + DIV_WIDTH'(1) : '0;

  // Outputs load from div_nxt so each clock pin is always the flopped copy of the current div bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      mclk  <= 1'b0;
      sclk  <= 1'b0;
      lrclk <= 1'b0;
    end else begin
      div   <= div_nxt;
      mclk  <= div_nxt[MCLK_BIT];
      sclk  <= div_nxt[SCLK_BIT];
      lrclk <= div_nxt[LRCLK_BIT];
    end
  end

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S ADC capture: deserialises stereo frames onto a valid/ready output with sticky overrun.
// Optional peak meter (peak_level/peak_clr) built when I2S_RX_PEAK_EN is defined.
module i2s_rx_capture
  import i2s_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int I2S_DELAY   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sdout,
  output logic                    mclk,
  output logic                    sclk,
  output logic                    lrclk,
  output logic signed [WIDTH-1:0] left_sample,
  output logic signed [WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  input  logic                    ovr_clr
`ifdef I2S_RX_PEAK_EN
  ,
  output logic [WIDTH-2:0]        peak_level,
  input  logic                    peak_clr
`endif
);

  logic [DIV_WIDTH-1:0]   div;
  logic [SYNC_STAGES-1:0] sync;
  logic [WIDTH-2:0]       shreg;
  logic [WIDTH-1:0]       word;
  logic [WIDTH-1:0]       staging;
  logic [3:0]             slot;
  logic                   prime;
  logic                   strobe;
  logic                   word_done;
  logic                   commit;
  channel_t               word_ch;

  i2s_clkgen u_clkgen (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .div   (div),
    .mclk  (mclk),
    .sclk  (sclk),
    .lrclk (lrclk)
  );

  assign slot   = div[LRCLK_BIT-1:SCLK_BIT+1];
  assign strobe = en && (div[SCLK_BIT:0] == SAMPLE_PHASE);
  // Only WIDTH-1 bits are stored: the word is complete the moment the last bit arrives.
  assign word   = {shreg, sync[SYNC_STAGES-1]};

  generate
    if (I2S_DELAY != 0) begin : g_i2s
      // Slot 0 carries the LSB of the word sent in the previous half.
      assign word_done = (slot == 4'd0);
      assign word_ch   = div[LRCLK_BIT] ? CH_LEFT : CH_RIGHT;
    end else begin : g_left_justified
      assign word_done = (slot == LAST_SLOT);
      assign word_ch   = div[LRCLK_BIT] ? CH_RIGHT : CH_LEFT;
    end
  endgenerate

  assign commit = strobe && word_done && (word_ch == CH_RIGHT) && prime;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync         <= '0;
      shreg        <= '0;
      staging      <= '0;
      prime        <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sdout};

      if (!en) begin
        shreg   <= '0;
        staging <= '0;
        prime   <= 1'b0;
      end else if (strobe) begin
        shreg <= word[WIDTH-2:0];
        if (word_done && word_ch == CH_LEFT) staging <= word;
        // The first right word after enable is partial; it only arms the commit path.
        if (word_done && word_ch == CH_RIGHT) prime <= 1'b1;
      end

      if (commit) begin
        left_sample  <= staging;
        right_sample <= word;
      end

      if (commit) sample_valid <= 1'b1;
      else if (sample_ready) sample_valid <= 1'b0;

      if (commit && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

`ifdef I2S_RX_PEAK_EN
  logic [WIDTH-2:0] mag_l;
  logic [WIDTH-2:0] mag_r;
  logic [WIDTH-2:0] frame_pk;

  function automatic logic [WIDTH-2:0] mag(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] n;
    n = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    return n[WIDTH-1] ? '1 : n[WIDTH-2:0];
  endfunction

  assign mag_l    = mag(staging);
  assign mag_r    = mag(word);
  assign frame_pk = (mag_l > mag_r) ? mag_l : mag_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_level <= '0;
    else if (commit) peak_level <= (peak_clr || frame_pk > peak_level) ? frame_pk : peak_level;
    else if (peak_clr) peak_level <= '0;
  end
`endif

endmodule
